// File: rtl/ysyx_exu_stq.sv
// Age-ordered store queue: in-order alloc/commit/drain with a head..cmt..tail ring,
// plus combinational store-to-load forwarding filtered by the load's tail snapshot.
module ysyx_exu_stq #(
  parameter  int SQ_SIZE = 8,
  parameter  int XLEN    = 32,
  localparam int PW      = $clog2(SQ_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipeline,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [PW-1:0]   alloc_ptr,
  input  logic            ex_valid,
  input  logic [PW-1:0]   ex_ptr,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic [1:0]      ex_op,
  input  logic            cm_valid,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [1:0]      mem_wop,
  input  logic            mem_wready,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [1:0]      ld_op,
  input  logic [PW-1:0]   ld_ptr,
  output logic            ld_hit,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_stall,
  output logic [PW-1:0]   count,
  output logic            empty
);

  localparam int IW = PW - 1;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_ALLOC = 2'd1,
    S_READY = 2'd2,
    S_CMTD  = 2'd3
  } ent_state_e;

  ent_state_e      st_q   [SQ_SIZE];
  ent_state_e      st_d   [SQ_SIZE];
  logic [XLEN-1:0] addr_q [SQ_SIZE];
  logic [XLEN-1:0] data_q [SQ_SIZE];
  logic [1:0]      op_q   [SQ_SIZE];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [IW-1:0] head_idx, cmt_idx, tail_idx, ex_idx;
  logic          full;
  logic          alloc_fire, ex_fire, cm_fire, drain_fire;
  logic [PW-1:0] ex_off;

  function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [1:0] op);
    logic [3:0] m;
    case (op)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [XLEN-1:0] d, input logic [1:0] op);
    case (op)
      2'd0:    return XLEN'(d[7:0]);
      2'd1:    return XLEN'(d[15:0]);
      default: return d;
    endcase
  endfunction

  assign head_idx = head_q[IW-1:0];
  assign cmt_idx  = cmt_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign ex_idx   = ex_ptr[IW-1:0];

  // Handshakes: a transfer happens on the edge where valid and ready are both high;
  // mem_wen and its payload hold until mem_wready, and alloc_ready never looks at
  // a same-cycle drain.
  assign full        = (tail_idx == head_idx) && (tail_q[PW-1] != head_q[PW-1]);
  assign alloc_ready = !full;
  assign alloc_ptr   = tail_q;
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);

  assign mem_wen   = (head_q != cmt_q);
  assign mem_waddr = addr_q[head_idx];
  assign mem_wdata = data_q[head_idx];
  assign mem_wop   = op_q[head_idx];

  assign ex_off     = ex_ptr - head_q;
  assign alloc_fire = alloc_valid && !full && !flush_pipeline;
  assign ex_fire    = ex_valid && !flush_pipeline && (ex_off < count) && (st_q[ex_idx] == S_ALLOC);
  assign cm_fire    = cm_valid && (st_q[cmt_idx] == S_READY);
  assign drain_fire = mem_wen && mem_wready;

  assign head_d = head_q + PW'(drain_fire);
  assign cmt_d  = cmt_q + PW'(cm_fire);
  // A same-cycle commit is kept: tail snaps to the post-commit cmt.
  assign tail_d = flush_pipeline ? cmt_d : tail_q + PW'(alloc_fire);

  always_comb begin
    for (int i = 0; i < SQ_SIZE; i++) begin
      st_d[i] = st_q[i];
      if (flush_pipeline && (st_q[i] == S_ALLOC || st_q[i] == S_READY)) st_d[i] = S_FREE;
    end
    if (ex_fire)    st_d[ex_idx]   = S_READY;
    if (cm_fire)    st_d[cmt_idx]  = S_CMTD;
    if (alloc_fire) st_d[tail_idx] = S_ALLOC;
    if (drain_fire) st_d[head_idx] = S_FREE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
        st_q[i]   <= S_FREE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        op_q[i]   <= '0;
      end
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      for (int i = 0; i < SQ_SIZE; i++) st_q[i] <= st_d[i];
      if (ex_fire) begin
        addr_q[ex_idx] <= ex_addr;
        data_q[ex_idx] <= ex_data;
        op_q[ex_idx]   <= ex_op;
      end
    end
  end

  logic [PW-1:0]   ld_off;
  logic [3:0]      ld_mask;
  logic [IW-1:0]   scan_idx;
  logic            any_alloc, fwd_found, fwd_exact;
  logic [XLEN-1:0] fwd_data;

  // Walk oldest to youngest so the last overlapping hit is the youngest older store.
  always_comb begin
    ld_hit    = 1'b0;
    ld_stall  = 1'b0;
    ld_data   = '0;
    any_alloc = 1'b0;
    fwd_found = 1'b0;
    fwd_exact = 1'b0;
    fwd_data  = '0;
    scan_idx  = '0;
    ld_off    = ld_ptr - head_q;
    ld_mask   = byte_mask(ld_addr[1:0], ld_op);
    for (int i = 0; i < SQ_SIZE; i++) begin
      scan_idx = head_idx + IW'(i);
      if ((PW'(i) < ld_off) && (PW'(i) < count)) begin
        if (st_q[scan_idx] == S_ALLOC) begin
          any_alloc = 1'b1;
        end else if ((addr_q[scan_idx][XLEN-1:2] == ld_addr[XLEN-1:2]) &&
                     ((byte_mask(addr_q[scan_idx][1:0], op_q[scan_idx]) & ld_mask) != 4'b0000)) begin
          fwd_found = 1'b1;
          fwd_exact = (addr_q[scan_idx] == ld_addr) && (op_q[scan_idx] == ld_op);
          fwd_data  = data_q[scan_idx];
        end
      end
    end
    if (ld_valid) begin
      ld_stall = any_alloc || (fwd_found && !fwd_exact);
      ld_hit   = fwd_found && fwd_exact && !any_alloc;
      if (ld_hit) ld_data = size_mask(fwd_data, ld_op);
    end
  end

endmodule

// File: tb/tb_ysyx_exu_stq.sv
// Bench for ysyx_exu_stq: directed sequences, a forwarding vector table, and
// randomized traffic compared against a queue-of-stores reference model.
module tb_ysyx_exu_stq;

  localparam int N  = 8;
  localparam int PW = 4;
  localparam int XL = 32;

  logic          clock, reset, flush_pipeline;
  logic          alloc_valid, alloc_ready;
  logic [PW-1:0] alloc_ptr;
  logic          ex_valid;
  logic [PW-1:0] ex_ptr;
  logic [XL-1:0] ex_addr, ex_data;
  logic [1:0]    ex_op;
  logic          cm_valid;
  logic          mem_wen, mem_wready;
  logic [XL-1:0] mem_waddr, mem_wdata;
  logic [1:0]    mem_wop;
  logic          ld_valid, ld_hit, ld_stall;
  logic [XL-1:0] ld_addr, ld_data;
  logic [1:0]    ld_op;
  logic [PW-1:0] ld_ptr, count;
  logic          empty;

  ysyx_exu_stq #(.SQ_SIZE(N), .XLEN(XL)) dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .ex_valid(ex_valid), .ex_ptr(ex_ptr), .ex_addr(ex_addr), .ex_data(ex_data), .ex_op(ex_op),
    .cm_valid(cm_valid),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wop(mem_wop),
    .mem_wready(mem_wready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_op(ld_op), .ld_ptr(ld_ptr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .count(count), .empty(empty)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush_pipeline = 0; alloc_valid = 0; ex_valid = 0; ex_ptr = '0;
    ex_addr = '0; ex_data = '0; ex_op = '0; cm_valid = 0; mem_wready = 0;
    ld_valid = 0; ld_addr = '0; ld_op = '0; ld_ptr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv_alloc();
    alloc_valid = 1; @(negedge clock); alloc_valid = 0;
  endtask

  task automatic drv_ex(input int p, input logic [31:0] a, input logic [31:0] d, input logic [1:0] o);
    ex_valid = 1; ex_ptr = PW'(p); ex_addr = a; ex_data = d; ex_op = o;
    @(negedge clock);
    ex_valid = 0;
  endtask

  task automatic drv_cm();
    cm_valid = 1; @(negedge clock); cm_valid = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          execd;
    bit          cmtd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
  } mst_t;

  mst_t mq[$];
  int   m_head;

  function automatic logic [31:0] smask(input logic [31:0] d, input logic [1:0] op);
    if (op == 2'd0) return d & 32'hFF;
    if (op == 2'd1) return d & 32'hFFFF;
    return d;
  endfunction

  function automatic int nbytes(input logic [1:0] op);
    return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
  endfunction

  // Loads see the n oldest stores in the queue.
  task automatic fwd_model(input int n, input logic [31:0] la, input logic [1:0] lo,
                           output logic hit, output logic stall, output logic [31:0] data);
    int found;
    stall = 0; found = -1; hit = 0; data = '0;
    for (int k = 0; k < n; k++) begin
      if (!mq[k].execd) stall = 1;
      else if ((longint'(mq[k].addr) < longint'(la) + nbytes(lo)) &&
               (longint'(la) < longint'(mq[k].addr) + nbytes(mq[k].op)))
        found = k;
    end
    if (found >= 0) begin
      if (mq[found].addr == la && mq[found].op == lo) begin
        if (!stall) begin hit = 1; data = smask(mq[found].data, lo); end
      end else begin
        stall = 1;
      end
    end
  endtask

  task automatic gen_addr(output logic [31:0] a, output logic [1:0] o);
    logic [31:0] base;
    o = 2'($urandom_range(0, 2));
    base = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h104;
    if (o == 2'd2)      a = base;
    else if (o == 2'd1) a = base + 32'($urandom_range(0, 1) * 2);
    else                a = base + 32'($urandom_range(0, 3));
  endtask

  // ---------------- forwarding vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    int          n_older;
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } fwd_vec_t;

  fwd_vec_t    fv[10];
  logic [31:0] exp_q[$];

  int sz, ex_idx, n_ld, nwr, cm_k;
  logic e_hit, e_stall;
  logic [31:0] e_data, ra;
  logic [1:0] ro;
  bit drain_f, cm_f;

  initial begin
    fv[0] = '{32'h100, 2'd2, 1, 1'b1, 1'b0, 32'hDEADBEEF};
    fv[1] = '{32'h100, 2'd2, 0, 1'b0, 1'b0, 32'h0};
    fv[2] = '{32'h102, 2'd0, 1, 1'b0, 1'b1, 32'h0};
    fv[3] = '{32'h103, 2'd0, 2, 1'b1, 1'b0, 32'h11};
    fv[4] = '{32'h103, 2'd0, 3, 1'b1, 1'b0, 32'h22};
    fv[5] = '{32'h101, 2'd0, 3, 1'b0, 1'b1, 32'h0};
    fv[6] = '{32'h200, 2'd2, 4, 1'b0, 1'b1, 32'h0};
    fv[7] = '{32'h300, 2'd2, 3, 1'b0, 1'b0, 32'h0};
    fv[8] = '{32'h102, 2'd1, 3, 1'b0, 1'b1, 32'h0};
    fv[9] = '{32'h100, 2'd2, 3, 1'b0, 1'b1, 32'h0};

    do_reset();
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_ptr", alloc_ptr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_ld_data", ld_data, 0);
    @(negedge clock);

    // Fill, commit, drain in allocation order
    for (int i = 0; i < N; i++) begin
      alloc_valid = 1;
      #1 chk("fill_alloc_ptr", alloc_ptr, i);
      @(negedge clock);
    end
    alloc_valid = 0;
    #1;
    chk("fill_count", count, 8);
    chk("fill_alloc_ready", alloc_ready, 0);
    @(negedge clock);
    drv_alloc();
    #1 chk("fill_refuse_count", count, 8);
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      drv_ex(i, 32'h1000 + 32'(i * 4), 32'h11111111 * 32'(i), 2'd2);
      exp_q.push_back(32'h1000 + 32'(i * 4));
    end
    for (int i = 0; i < N; i++) drv_cm();
    mem_wready = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      chk("drain_wen", mem_wen, 1);
      chk("drain_addr", mem_waddr, exp_q.pop_front());
      @(negedge clock);
    end
    mem_wready = 0;
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_wen_low", mem_wen, 0);
    @(negedge clock);

    // Wrap-around
    do_reset();
    for (int k = 0; k < 12; k++) begin
      alloc_valid = 1;
      #1 chk("wrap_alloc_ptr", alloc_ptr, k);
      @(negedge clock);
      alloc_valid = 0;
      drv_ex(k, 32'h40, 32'(k), 2'd2);
      drv_cm();
      mem_wready = 1; @(negedge clock); mem_wready = 0;
    end
    #1;
    chk("wrap_empty", empty, 1);
    chk("wrap_ready", alloc_ready, 1);
    @(negedge clock);
    for (int k = 0; k < N; k++) begin
      alloc_valid = 1;
      #1 chk("wrap_fill_ptr", alloc_ptr, (12 + k) % 16);
      @(negedge clock);
    end
    alloc_valid = 0;
    #1;
    chk("wrap_full_ready", alloc_ready, 0);
    chk("wrap_full_count", count, 8);
    chk("wrap_full_empty", empty, 0);
    @(negedge clock);

    // Flush keeps only committed stores
    do_reset();
    for (int i = 0; i < 5; i++) drv_alloc();
    for (int i = 0; i < 5; i++) drv_ex(i, 32'h80 + 32'(i * 4), 32'(i), 2'd2);
    drv_cm(); drv_cm();
    flush_pipeline = 1; @(negedge clock); flush_pipeline = 0;
    #1;
    chk("flush_count", count, 2);
    chk("flush_alloc_ptr", alloc_ptr, 2);
    @(negedge clock);
    nwr = 0;
    mem_wready = 1;
    for (int i = 0; i < 8; i++) begin
      #1 if (mem_wen) nwr++;
      @(negedge clock);
    end
    mem_wready = 0;
    #1;
    chk("flush_writes", nwr, 2);
    chk("flush_next_ptr", alloc_ptr, 2);
    @(negedge clock);

    // Forwarding table
    do_reset();
    for (int i = 0; i < 4; i++) drv_alloc();
    drv_ex(0, 32'h100, 32'hDEADBEEF, 2'd2);
    drv_ex(1, 32'h103, 32'h11, 2'd0);
    drv_ex(2, 32'h103, 32'h22, 2'd0);
    for (int v = 0; v < 10; v++) begin
      ld_valid = 1; ld_addr = fv[v].addr; ld_op = fv[v].op; ld_ptr = PW'(fv[v].n_older);
      #1;
      chk($sformatf("fwd%0d_hit", v), ld_hit, fv[v].hit);
      chk($sformatf("fwd%0d_stall", v), ld_stall, fv[v].stall);
      if (fv[v].hit) chk($sformatf("fwd%0d_data", v), ld_data, fv[v].data);
      @(negedge clock);
    end
    ld_valid = 0; ld_addr = 32'h102; ld_op = 2'd0; ld_ptr = 4'd1;
    #1 chk("fwd_noquery_stall", ld_stall, 0);
    @(negedge clock);

    // Backpressure then async reset mid-hold
    do_reset();
    drv_alloc();
    drv_ex(0, 32'h40, 32'hCAFEF00D, 2'd2);
    drv_cm();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_wen", mem_wen, 1);
      chk("bp_addr", mem_waddr, 32'h40);
      chk("bp_data", mem_wdata, 32'hCAFEF00D);
      chk("bp_op", mem_wop, 2);
      @(negedge clock);
    end
    reset = 1;
    #1;
    chk("rst_mid_wen", mem_wen, 0);
    chk("rst_mid_count", count, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);

    // Randomized traffic against the queue model
    do_reset();
    mq.delete();
    m_head = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      sz = mq.size();
      idle();
      alloc_valid = ($urandom_range(0, 99) < 45);
      ex_idx = -1;
      if (sz > 0 && $urandom_range(0, 99) < 60) begin
        ex_idx = int'($urandom_range(0, sz - 1));
        ex_valid = 1;
        ex_ptr = PW'((m_head + ex_idx) % 16);
        gen_addr(ra, ro);
        ex_addr = ra; ex_op = ro; ex_data = $urandom;
      end
      cm_valid = ($urandom_range(0, 99) < 50);
      mem_wready = ($urandom_range(0, 99) < 60);
      flush_pipeline = ($urandom_range(0, 99) < 4);
      n_ld = int'($urandom_range(0, sz));
      ld_valid = ($urandom_range(0, 99) < 70);
      ld_ptr = PW'((m_head + n_ld) % 16);
      gen_addr(ra, ro);
      ld_addr = ra; ld_op = ro;
      #1;
      chk("r_alloc_ready", alloc_ready, sz < N);
      chk("r_alloc_ptr", alloc_ptr, (m_head + sz) % 16);
      chk("r_count", count, sz);
      chk("r_empty", empty, sz == 0);
      chk("r_mem_wen", mem_wen, sz > 0 && mq[0].cmtd);
      if (sz > 0 && mq[0].cmtd) begin
        chk("r_waddr", mem_waddr, mq[0].addr);
        chk("r_wdata", mem_wdata, mq[0].data);
        chk("r_wop", mem_wop, mq[0].op);
      end
      if (ld_valid) fwd_model(n_ld, ld_addr, ld_op, e_hit, e_stall, e_data);
      else begin e_hit = 0; e_stall = 0; e_data = '0; end
      chk("r_ld_hit", ld_hit, e_hit);
      chk("r_ld_stall", ld_stall, e_stall);
      if (e_hit) chk("r_ld_data", ld_data, e_data);

      // model update from pre-edge state
      drain_f = (sz > 0) && mq[0].cmtd && mem_wready;
      cm_k = -1;
      for (int k = 0; k < sz; k++) if (cm_k < 0 && !mq[k].cmtd) cm_k = k;
      cm_f = cm_valid && (cm_k >= 0) && mq[cm_k].execd;
      if (cm_f) mq[cm_k].cmtd = 1;
      if (ex_idx >= 0 && !flush_pipeline && !mq[ex_idx].execd) begin
        mq[ex_idx].execd = 1;
        mq[ex_idx].addr = ex_addr; mq[ex_idx].data = ex_data; mq[ex_idx].op = ex_op;
      end
      if (flush_pipeline)
        while (mq.size() > 0 && !mq[mq.size() - 1].cmtd) void'(mq.pop_back());
      if (drain_f) begin
        void'(mq.pop_front());
        m_head = (m_head + 1) % 16;
      end
      if (alloc_valid && sz < N && !flush_pipeline)
        mq.push_back('{execd: 0, cmtd: 0, addr: '0, data: '0, op: '0});
      @(negedge clock);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
